// File: rtl/db9_multitap_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : db9_multitap_scanner
//  Purpose  : Time-multiplexed DB9 joystick scanner. Steps the splitter
//             select lines through the player ports and samples the shared
//             active-low DB9 pins once per port slot after a settle delay.
//             Delivers debounced, positive-logic button state per player.
//  Ports    : CLK_50M     - system clock
//             reset       - synchronous, active-high
//             db9_n       - DB9 pins, active-low, asynchronous
//             mode        - 0 OFF, 1 DIRECT, 2 SPLIT, 3 OFF
//             direct_port - destination port in DIRECT mode
//             sel_out     - splitter select (binary port index)
//             joy_out     - port p at [p*BTN_W +: BTN_W], positive logic
//             frame_done  - 1-cycle pulse after the last port of a scan
//  Revision : 1.0 - initial release
// ============================================================================
module db9_multitap_scanner #(
  parameter int NUM_PORTS     = 2,
  parameter int BTN_W         = 6,
  parameter int SETTLE_CYCLES = 255,
  parameter int DEBOUNCE      = 2,
  parameter int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       CLK_50M,
  input  logic                       reset,
  input  logic [BTN_W-1:0]           db9_n,
  input  logic [1:0]                 mode,
  input  logic [PW-1:0]              direct_port,
  output logic [PW-1:0]              sel_out,
  output logic [NUM_PORTS*BTN_W-1:0] joy_out,
  output logic                       frame_done
);

  localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]   LAST_PORT   = PW'(NUM_PORTS - 1);
  localparam logic [3:0]      DB_MIN      = 4'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t              state;
  logic [BTN_W-1:0]    sync1, sync2;
  logic [BTN_W-1:0]    s;
  logic [1:0]          mode_r;
  logic [PW-1:0]       dp_r;
  logic [PW-1:0]       cur;
  logic [SW-1:0]       scnt;
  logic [BTN_W-1:0]    prev  [NUM_PORTS];
  logic [3:0]          dcnt  [NUM_PORTS];
  logic [BTN_W-1:0]    joy_r [NUM_PORTS];

  logic                dp_bad;
  logic                mode_chg;
  logic                is_split;
  logic                is_direct;
  logic [3:0]          next_cnt;

  // Pins idle high, so the synchroniser resets to the released state.
  assign s = ~sync2;

  // An out-of-range direct port is only representable when NUM_PORTS is
  // not a power of two.
  generate
    if (NUM_PORTS == (1 << PW)) begin : g_dp_full
      assign dp_bad = 1'b0;
    end else begin : g_dp_part
      assign dp_bad = (dp_r >= PW'(NUM_PORTS));
    end
  endgenerate

  // A new direct_port while DIRECT is requested restarts the scan like a mode change.
  assign mode_chg  = (mode != mode_r) || ((mode == 2'd1) && (direct_port != dp_r));
  assign is_split  = (mode_r == 2'd2);
  assign is_direct = (mode_r == 2'd1) && !dp_bad;

  // Post-update run length of the port being sampled (saturating at 15).
  assign next_cnt = (s != prev[cur]) ? 4'd0 :
                    (dcnt[cur] == 4'd15) ? 4'd15 : dcnt[cur] + 4'd1;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state      <= IDLE;
      sync1      <= '1;
      sync2      <= '1;
      mode_r     <= 2'd0;
      dp_r       <= '0;
      cur        <= '0;
      scnt       <= '0;
      sel_out    <= '0;
      frame_done <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        prev[p]  <= '0;
        dcnt[p]  <= '0;
        joy_r[p] <= '0;
      end
    end else begin
      sync1      <= db9_n;
      sync2      <= sync1;
      mode_r     <= mode;
      dp_r       <= direct_port;
      frame_done <= 1'b0;

      if (mode_chg) begin
        state   <= IDLE;
        cur     <= '0;
        sel_out <= '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          prev[p]  <= '0;
          dcnt[p]  <= '0;
          joy_r[p] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!is_split && !is_direct) begin
              for (int p = 0; p < NUM_PORTS; p++) joy_r[p] <= '0;
            end else begin
              cur     <= is_direct ? dp_r : '0;
              sel_out <= '0;
              scnt    <= '0;
              state   <= SETTLE;
            end
          end

          SETTLE: begin
            if (scnt == SETTLE_LAST) state <= SAMPLE;
            else                     scnt  <= scnt + 1'b1;
          end

          SAMPLE: begin
            prev[cur] <= s;
            dcnt[cur] <= next_cnt;
            if (next_cnt >= DB_MIN) joy_r[cur] <= s;
            scnt  <= '0;
            state <= SETTLE;
            if (is_direct) begin
              frame_done <= 1'b1;
            end else if (cur == LAST_PORT) begin
              cur        <= '0;
              sel_out    <= '0;
              frame_done <= 1'b1;
            end else begin
              cur     <= cur + 1'b1;
              sel_out <= cur + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_pack
      assign joy_out[g*BTN_W +: BTN_W] = joy_r[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_db9_multitap_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_db9_multitap_scanner
//  Purpose  : Directed self-checking bench. Instance A (2 ports, 255-cycle
//             settle) models a 2-way splitter in front of the DB9 pins;
//             instance B (4 ports, 3-cycle settle) checks the select stepping.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_db9_multitap_scanner;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: two players behind a splitter.
  logic [5:0]  pat_a0, pat_a1;
  logic [5:0]  db9_a;
  logic [1:0]  mode_a;
  logic        direct_a;
  logic        sel_a;
  logic [11:0] joy_a;
  logic        fd_a;
  assign db9_a = (sel_a == 1'b0) ? pat_a0 : pat_a1;

  // Instance B: four players, player p presses button bit p.
  logic [5:0]  db9_b;
  logic [1:0]  mode_b;
  logic [1:0]  direct_b;
  logic [1:0]  sel_b;
  logic [23:0] joy_b;
  logic        fd_b;
  assign db9_b = ~(6'h01 << sel_b);

  db9_multitap_scanner #(.NUM_PORTS(2), .BTN_W(6), .SETTLE_CYCLES(255), .DEBOUNCE(2)) u_dut_a (
    .CLK_50M(clk), .reset(reset), .db9_n(db9_a), .mode(mode_a), .direct_port(direct_a),
    .sel_out(sel_a), .joy_out(joy_a), .frame_done(fd_a));

  db9_multitap_scanner #(.NUM_PORTS(4), .BTN_W(6), .SETTLE_CYCLES(3), .DEBOUNCE(2)) u_dut_b (
    .CLK_50M(clk), .reset(reset), .db9_n(db9_b), .mode(mode_b), .direct_port(direct_b),
    .sel_out(sel_b), .joy_out(joy_b), .frame_done(fd_b));

  // Watches for any non-zero select while DIRECT is being observed.
  logic mon_en = 1'b0;
  logic sel_nz = 1'b0;
  always @(negedge clk) begin
    if (!mon_en)            sel_nz = 1'b0;
    else if (sel_a != 1'b0) sel_nz = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd_a(output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (fd_a !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    check("a_frame_timeout", 32'(k >= 2000), 32'd0);
    t = cyc;
  endtask

  task automatic wait_fd_b(output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (fd_b !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("b_frame_timeout", 32'(k >= 100), 32'd0);
    t = cyc;
  endtask

  task automatic wait_sel_a(output int t);
    int k;
    logic old;
    k = 0;
    old = sel_a;
    @(negedge clk);
    while (sel_a === old && k < 1000) begin @(negedge clk); k++; end
    check("a_sel_timeout", 32'(k >= 1000), 32'd0);
    t = cyc;
  endtask

  task automatic wait_sel_b(output int t);
    int k;
    logic [1:0] old;
    k = 0;
    old = sel_b;
    @(negedge clk);
    while (sel_b === old && k < 100) begin @(negedge clk); k++; end
    check("b_sel_timeout", 32'(k >= 100), 32'd0);
    t = cyc;
  endtask

  int t1, t2, ta, tb_t, k;
  logic [1:0] exp_seq [5];

  initial begin
    reset    = 1'b1;
    mode_a   = 2'd0;
    mode_b   = 2'd0;
    direct_a = 1'b0;
    direct_b = 2'd0;
    pat_a0   = 6'h3E;
    pat_a1   = 6'h3D;
    exp_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    step(4);
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_joy_a", 32'(joy_a), 32'd0);
    check("rst_fd_a",  32'(fd_a),  32'd0);
    check("rst_sel_b", 32'(sel_b), 32'd0);
    check("rst_joy_b", 32'(joy_b), 32'd0);
    reset = 1'b0;
    step(2);

    // Four ports, 4-clock slots: select walks 0,1,2,3,0 with frame_done on the wrap.
    mode_b = 2'd2;
    wait_sel_b(t1);
    check("b_seq0", 32'(sel_b), 32'(exp_seq[0]));
    for (int i = 1; i < 5; i++) begin
      wait_sel_b(t2);
      check("b_seq", 32'(sel_b), 32'(exp_seq[i]));
      check("b_slot_period", 32'(t2 - t1), 32'd4);
      check("b_fd_at_wrap", 32'(fd_b), (exp_seq[i] == 2'd0) ? 32'd1 : 32'd0);
      t1 = t2;
    end
    wait_fd_b(t1);
    check("b_joy_frame2", 32'(joy_b), 32'h204081);
    mode_b = 2'd0;
    step(2);
    check("b_joy_off", 32'(joy_b), 32'd0);

    // Two-player split: debounce needs two frames.
    mode_a = 2'd2;
    wait_fd_a(t1);
    check("a_joy_frame1", 32'(joy_a), 32'h000);
    step(1);
    check("a_fd_one_cycle", 32'(fd_a), 32'd0);
    wait_fd_a(t2);
    check("a_frame_period", 32'(t2 - t1), 32'd512);
    check("a_joy_frame2", 32'(joy_a), 32'h081);
    wait_sel_a(ta);
    wait_sel_a(tb_t);
    check("a_sel_period", 32'(tb_t - ta), 32'd256);

    // SPLIT -> OFF in the middle of the port 1 settle window.
    k = 0;
    while (sel_a !== 1'b1 && k < 600) begin step(1); k++; end
    check("a_sel1_timeout", 32'(k >= 600), 32'd0);
    step(50);
    mode_a = 2'd0;
    step(1);
    check("a_off_joy", 32'(joy_a), 32'd0);
    check("a_off_fd",  32'(fd_a),  32'd0);
    step(5);
    check("a_off_joy_hold", 32'(joy_a), 32'd0);

    // Back to SPLIT with a one-slot glitch on port 0.
    pat_a0 = 6'h2F;
    mode_a = 2'd2;
    step(3);
    check("a_restart_sel", 32'(sel_a), 32'd0);
    wait_fd_a(t1);
    pat_a0 = 6'h3E;
    check("a_glitch_f1", 32'(joy_a), 32'h000);
    wait_fd_a(t1);
    check("a_glitch_f2", 32'(joy_a), 32'h080);
    wait_fd_a(t1);
    check("a_glitch_f3", 32'(joy_a), 32'h081);

    // DIRECT to port 1: port 0 stays clear, select pinned to 0.
    pat_a0   = 6'h1F;
    pat_a1   = 6'h1F;
    direct_a = 1'b1;
    mode_a   = 2'd1;
    wait_fd_a(t1);
    check("a_direct_f1", 32'(joy_a), 32'h000);
    mon_en = 1'b1;
    wait_fd_a(t2);
    check("a_direct_period", 32'(t2 - t1), 32'd256);
    check("a_direct_f2", 32'(joy_a), 32'h800);
    check("a_direct_sel0", 32'(sel_nz), 32'd0);
    mon_en = 1'b0;

    // Reset held 3 cycles in the middle of a settle window.
    step(100);
    reset = 1'b1;
    step(1);
    check("a_midrst_sel", 32'(sel_a), 32'd0);
    check("a_midrst_joy", 32'(joy_a), 32'd0);
    check("a_midrst_fd",  32'(fd_a),  32'd0);
    step(2);
    check("a_midrst_joy3", 32'(joy_a), 32'd0);
    reset = 1'b0;

    // DIRECT resumes after reset; a direct_port change clears like a mode change.
    wait_fd_a(t1);
    wait_fd_a(t1);
    check("a_direct_resume", 32'(joy_a), 32'h800);
    direct_a = 1'b0;
    step(1);
    check("a_dp_change_clear", 32'(joy_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
